// File: rtl/div_pkg.sv
// Shared types and sizing for the div_u restoring divider and its iteration step.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEF = 32;
  localparam int CNT_W         = $clog2(DIV_WIDTH_DEF);

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational iteration of radix-2 restoring division:
// shift {A,Q} left, trial-subtract D, and keep or restore the partial remainder.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH+1:0] w_shA;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;

  // One extra guard bit above A makes the borrow of the trial subtraction visible.
  always_comb begin
    w_shA  = {i_a, i_q[WIDTH-1]};
    w_diff = w_shA - {2'b00, i_d};
    w_neg  = w_diff[WIDTH+1];
    o_q    = {i_q[WIDTH-2:0], ~w_neg};
    o_a    = w_neg ? w_shA[WIDTH:0] : w_diff[WIDTH:0];
  end

endmodule

// File: rtl/div_u.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, start/done handshake.
// Optional DIV_ZERO_ERR_EN: adds the err port and a one-cycle fast path for D=0.
module div_u
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
`ifdef DIV_ZERO_ERR_EN
  output logic             done,
  output logic             err
`else
  output logic             done
`endif
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       r_state;
  div_state_t       w_nextState;
  logic             w_accept;
  logic             w_zeroFast;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH:0]   w_stepA;
  logic [WIDTH-1:0] w_stepQ;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_d (r_d),
    .o_a (w_stepA),
    .o_q (w_stepQ)
  );

`ifdef DIV_ZERO_ERR_EN
  assign w_zeroFast = (D == '0);
`else
  assign w_zeroFast = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = w_zeroFast ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath: operands latch on accept; results latch on the last iteration,
  // or directly on accept when the divide-by-zero fast path is taken.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_a    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_a   <= '0;
      r_q   <= N;
      r_d   <= D;
      r_cnt <= CW'(WIDTH - 1);
      if (w_zeroFast) begin
        r_quot <= '1;
        r_rem  <= N;
      end
    end else if (r_state == RUN) begin
      r_a   <= w_stepA;
      r_q   <= w_stepQ;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == '0) begin
        r_quot <= w_stepQ;
        r_rem  <= w_stepA[WIDTH-1:0];
      end
    end
  end

`ifdef DIV_ZERO_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_zeroFast;
    end
  end

  assign err = r_err;
`endif

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_div_u.sv
// Scoreboard bench for div_u: stimulus pushes expected results, a negedge monitor checks each done.
// Build with or without +define+DIV_ZERO_ERR_EN; expectations follow the macro.
module tb_div_u;

  localparam int WIDTH = 32;

`ifdef DIV_ZERO_ERR_EN
  localparam bit ZeroFast = 1'b1;
`else
  localparam bit ZeroFast = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             nRst;
  logic [WIDTH-1:0] nIn;
  logic [WIDTH-1:0] dIn;
  logic             startIn;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
`ifdef DIV_ZERO_ERR_EN
  logic             err;
`endif

  always #5 clk = ~clk;

  div_u #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .n_rst     (nRst),
    .N         (nIn),
    .D         (dIn),
    .start     (startIn),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
`ifdef DIV_ZERO_ERR_EN
    .done      (done),
    .err       (err)
`else
    .done      (done)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             e;
    int               doneCyc;
    int               busyCyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             monExp;
  int               cyc = 0;
  int               compared = 0;
  int               mismatched = 0;
  int               busyCnt = 0;
  logic [WIDTH-1:0] lastQ = '0;
  logic [WIDTH-1:0] lastR = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands; D=0 yields all ones and N.
  function automatic exp_t refModel(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    exp_t e;
    bit   fast;
    fast      = ZeroFast && (d == '0);
    e.q       = (d == '0) ? '1 : n / d;
    e.r       = (d == '0) ? n : n % d;
    e.e       = fast;
    e.busyCyc = fast ? 0 : WIDTH;
    e.doneCyc = fast ? 0 : WIDTH;
    return e;
  endfunction

  // Accept happens at the next rising edge; done is seen at the negedge WIDTH edges later.
  task automatic applyStimulus(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d, input bit hold);
    exp_t e;
    @(negedge clk);
    nIn     = n;
    dIn     = d;
    startIn = 1'b1;
    e = refModel(n, d);
    e.doneCyc = e.doneCyc + cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) startIn = 1'b0;
    nIn = $urandom;
    dIn = $urandom;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drainTimeout", sb.size(), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!nRst) begin
      busyCnt = 0;
    end else begin
      if (busy) busyCnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("spuriousDone", 32'd1, 32'd0);
        end else begin
          monExp = sb.pop_front();
          checkOutput("quotient", quotient, monExp.q);
          checkOutput("remainder", remainder, monExp.r);
          checkOutput("doneCycle", cyc, monExp.doneCyc);
          checkOutput("busyCycles", busyCnt, monExp.busyCyc);
`ifdef DIV_ZERO_ERR_EN
          checkOutput("err", 32'(err), 32'(monExp.e));
`endif
          lastQ = monExp.q;
          lastR = monExp.r;
        end
        busyCnt = 0;
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] d;
    exp_t             e;
    nRst    = 1'b0;
    startIn = 1'b0;
    nIn     = '0;
    dIn     = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstQuotient", quotient, 32'd0);
    checkOutput("rstRemainder", remainder, 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
`ifdef DIV_ZERO_ERR_EN
    checkOutput("rstErr", 32'(err), 32'd0);
`endif
    nRst = 1'b1;

    applyStimulus(32'h14, 32'h8, 1'b0);
    waitIdle();
    checkOutput("holdQuotient", quotient, lastQ);
    checkOutput("holdRemainder", remainder, lastR);
    applyStimulus(32'h5, 32'hF, 1'b0);
    waitIdle();
    applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0);
    waitIdle();
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitIdle();
    applyStimulus(32'h0, 32'h9, 1'b0);
    waitIdle();

    // A start during RUN must be dropped without producing a second done.
    applyStimulus(32'h14, 32'h8, 1'b0);
    repeat (4) @(negedge clk);
    nIn     = 32'd9;
    dIn     = 32'd3;
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    waitIdle();

    // Reset mid-RUN aborts: outputs clear and no done follows.
    applyStimulus(32'hABCD_EF01, 32'h13, 1'b0);
    repeat (8) @(negedge clk);
    nRst = 1'b0;
    sb.delete();
    @(negedge clk);
    nRst = 1'b1;
    checkOutput("abortQuotient", quotient, 32'd0);
    checkOutput("abortRemainder", remainder, 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortDone", 32'(done), 32'd0);
    repeat (40) @(negedge clk);
    applyStimulus(32'd100, 32'd7, 1'b0);
    waitIdle();

    applyStimulus(32'h1234, 32'h0, 1'b0);
    waitIdle();
    applyStimulus(32'd1000, 32'd10, 1'b0);
    waitIdle();

    // Start held high: the second operation is accepted two edges after done is seen.
    applyStimulus(32'd50, 32'd6, 1'b1);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    checkOutput("heldDoneSeen", 32'(done), 32'd1);
    nIn = 32'd77;
    dIn = 32'd5;
    e = refModel(32'd77, 32'd5);
    e.doneCyc = e.doneCyc + cyc + 2;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    startIn = 1'b0;
    waitIdle();

    for (int k = 0; k < 20; k++) begin
      n = $urandom;
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 4) == 0) n = n >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) d = '0;
      applyStimulus(n, d, 1'b0);
      waitIdle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
